fp_addsub_pipe: RTL

//  Pipelined IEEE-754 adder/subtractor, parametrised in exponent/fraction width.

---
 rtl/fp_pkg.sv | 65 ++++++
 rtl/fp_norm_round.sv | 99 +++++++++
 rtl/fp_addsub_pipe.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared definitions for the pipelined floating-point
//                adder/subtractor: operand classes, flag bit positions,
//                binary32 reference constants and a leading-zero counter.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package fp_pkg;

  // Reference constants for the default (binary32) configuration.
  localparam int          DEF_EXP_W  = 8;
  localparam int          DEF_FRAC_W = 23;
  localparam int          BIAS       = (1 << (DEF_EXP_W - 1)) - 1;
  localparam int          EXP_MAX    = (1 << DEF_EXP_W) - 1;
  localparam logic [31:0] QNAN_32    = 32'h7FC0_0000;

  // Positions inside the 4-bit status word {invalid, overflow, underflow, inexact}.
  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

  // The leading-zero counter works on a left-justified vector of this width,
  // so any mantissa datapath up to LZC_W bits can share it.
  localparam int LZC_W     = 128;
  localparam int LZC_CNT_W = 8;

  typedef enum logic [2:0] {
    CLS_ZERO = 3'd0,
    CLS_SUB  = 3'd1,
    CLS_NORM = 3'd2,
    CLS_INF  = 3'd3,
    CLS_NAN  = 3'd4
  } fp_class_e;

  // Width-independent classification from the three field summaries.
  function automatic fp_class_e classify(input logic exp_zero,
                                         input logic exp_ones,
                                         input logic frac_zero);
    fp_class_e c;
    if (exp_zero)       c = frac_zero ? CLS_ZERO : CLS_SUB;
    else if (exp_ones)  c = frac_zero ? CLS_INF  : CLS_NAN;
    else                c = CLS_NORM;
    return c;
  endfunction

  // Number of leading zeros of a left-justified vector (LZC_W for all-zero).
  function automatic logic [LZC_CNT_W-1:0] lzc(input logic [LZC_W-1:0] v);
    logic [LZC_CNT_W-1:0] n;
    logic                 found;
    n     = '0;
    found = 1'b0;
    for (int i = LZC_W - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n     = n + 1'b1;
      end
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_norm_round.sv
`default_nettype none
// ============================================================================
//  Module      : fp_norm_round
//  Description : Combinational third-stage datapath. Normalises the raw
//                magnitude sum, rounds to nearest-even on guard/round/sticky,
//                detects overflow/underflow (flush-to-zero) and merges the
//                special-case result carried down the pipe.
//  Ports       : sign      - result sign (sign of larger operand)
//                exp_in    - exponent of larger operand
//                sum       - {carry, hidden, fraction, G, R, S}
//                spec*     - special-case bypass request, value and flags
//                res, flg  - packed IEEE result and {inv, ovf, unf, inx}
//  Revision    : 1.0  initial release
// ============================================================================
module fp_norm_round
  import fp_pkg::*;
#(
  parameter  int EXP_W      = 8,
  parameter  int FRAC_W     = 23,
  localparam int DATA_WIDTH = 1 + EXP_W + FRAC_W
) (
  input  logic                  sign,
  input  logic [EXP_W-1:0]      exp_in,
  input  logic [FRAC_W+4:0]     sum,
  input  logic                  spec,
  input  logic [DATA_WIDTH-1:0] spec_res,
  input  logic [3:0]            spec_flg,
  output logic [DATA_WIDTH-1:0] res,
  output logic [3:0]            flg
);

  localparam int XW = FRAC_W + 4;
  // Signed exponent work width: room for the largest left shift below zero.
  localparam int EW = (EXP_W + 2 > 10) ? EXP_W + 2 : 10;
  localparam logic signed [EW-1:0] EXP_MAX_L = EW'((1 << EXP_W) - 1);

  logic [LZC_CNT_W-1:0]  lz;
  logic [XW-1:0]         norm;
  logic signed [EW-1:0]  e_pre;
  logic signed [EW-1:0]  e_fin;
  logic [FRAC_W:0]       rnd_frac;
  logic                  rnd_up;
  logic                  inexact;
  logic                  ovf;
  logic                  unf;

  always_comb begin
    lz       = lzc({sum[XW-1:0], {(LZC_W - XW){1'b0}}});
    norm     = '0;
    e_pre    = '0;
    rnd_frac = '0;
    rnd_up   = 1'b0;
    inexact  = 1'b0;
    e_fin    = '0;
    ovf      = 1'b0;
    unf      = 1'b0;
    res      = '0;
    flg      = '0;

    if (sum[XW]) begin
      // Carry out of the adder: one-bit right shift, the dropped bit joins sticky.
      norm  = sum[XW:1] | {{(XW-1){1'b0}}, sum[0]};
      e_pre = {{(EW-EXP_W){1'b0}}, exp_in} + EW'(1);
    end else begin
      norm  = sum[XW-1:0] << lz;
      e_pre = {{(EW-EXP_W){1'b0}}, exp_in} - EW'(lz);
    end

    // norm = {hidden, frac, G, R, S}; round up on G with (R|S|lsb) for ties-to-even.
    rnd_up   = norm[2] & (norm[1] | norm[0] | norm[3]);
    inexact  = norm[2] | norm[1] | norm[0];
    rnd_frac = {1'b0, norm[XW-2:3]} + {{FRAC_W{1'b0}}, rnd_up};
    // A carry out of the fraction turns 1.11..1 into 10.00..0: bump the exponent.
    e_fin    = e_pre + {{(EW-1){1'b0}}, rnd_frac[FRAC_W]};
    ovf      = !e_fin[EW-1] && (e_fin >= EXP_MAX_L);
    unf      = e_fin[EW-1] || (e_fin == '0);

    if (spec) begin
      res = spec_res;
      flg = spec_flg;
    end else if (!norm[XW-1]) begin
      // Exact cancellation always yields +0.
      res = '0;
    end else if (ovf) begin
      res          = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      flg[FLG_OVF] = 1'b1;
      flg[FLG_INX] = 1'b1;
    end else if (unf) begin
      res          = {sign, {(EXP_W + FRAC_W){1'b0}}};
      flg[FLG_UNF] = 1'b1;
      flg[FLG_INX] = 1'b1;
    end else begin
      res          = {sign, e_fin[EXP_W-1:0], rnd_frac[FRAC_W-1:0]};
      flg[FLG_INX] = inexact;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_addsub_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fp_addsub_pipe
//  Description : Three-stage pipelined IEEE-754 adder/subtractor with
//                round-to-nearest-even, flush-to-zero on subnormal inputs and
//                outputs, NaN/Inf/zero handling and valid/ready flow control.
//                Stage 1 aligns, stage 2 adds, stage 3 normalises and rounds.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                in_valid/in_ready   - operand handshake
//                a, b, symbol        - operands, 0 = a+b, 1 = a-b
//                out_valid/out_ready - result handshake
//                out, flags          - result, {invalid, overflow, underflow, inexact}
//  Revision    : 1.0  initial release
// ============================================================================
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter  int EXP_W      = 8,
  parameter  int FRAC_W     = 23,
  localparam int DATA_WIDTH = 1 + EXP_W + FRAC_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  symbol,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out,
  output logic [3:0]            flags
);

  localparam int XW = FRAC_W + 4;   // hidden + fraction + G + R + S
  localparam logic [31:0] SHIFT_LIM = 32'(FRAC_W + 3);
  localparam logic [DATA_WIDTH-1:0] QNAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};

  // ---------------------------------------------------------------- stall chain
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s3_valid_q, s3_valid_d;
  logic s1_ready, s2_ready, s3_ready;

  // A stage can take new data when it is empty or its content moves on.
  assign s3_ready  = !s3_valid_q | out_ready;
  assign s2_ready  = !s2_valid_q | s3_ready;
  assign s1_ready  = !s1_valid_q | s2_ready;
  assign in_ready  = s1_ready;
  assign out_valid = s3_valid_q;

  // ---------------------------------------------------------------- stage 1: align
  logic                  a_sign, b_sign;
  logic [EXP_W-1:0]      a_exp, b_exp;
  logic [FRAC_W-1:0]     a_frac, b_frac;
  fp_class_e             a_cls, b_cls;
  logic                  a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic                  swap;
  logic                  big_sign;
  logic [EXP_W-1:0]      big_exp, sml_exp, shift_d;
  logic [FRAC_W-1:0]     big_frac, sml_frac;
  logic [2*XW-1:0]       wide;
  logic [XW-1:0]         al_ma, al_mb;
  logic                  al_spec;
  logic [DATA_WIDTH-1:0] al_spec_res;
  logic [3:0]            al_spec_flg;

  always_comb begin
    a_sign = a[DATA_WIDTH-1];
    a_exp  = a[DATA_WIDTH-2:FRAC_W];
    a_frac = a[FRAC_W-1:0];
    b_sign = b[DATA_WIDTH-1] ^ symbol;     // subtraction = add with flipped sign
    b_exp  = b[DATA_WIDTH-2:FRAC_W];
    b_frac = b[FRAC_W-1:0];

    a_cls  = classify(a_exp == '0, a_exp == EXP_ONES, a_frac == '0);
    b_cls  = classify(b_exp == '0, b_exp == EXP_ONES, b_frac == '0);
    // Subnormals are treated as zero on input.
    a_zero = (a_cls == CLS_ZERO) || (a_cls == CLS_SUB);
    b_zero = (b_cls == CLS_ZERO) || (b_cls == CLS_SUB);
    a_inf  = (a_cls == CLS_INF);
    b_inf  = (b_cls == CLS_INF);
    a_nan  = (a_cls == CLS_NAN);
    b_nan  = (b_cls == CLS_NAN);

    swap     = {b_exp, b_frac} > {a_exp, a_frac};
    big_sign = swap ? b_sign : a_sign;
    big_exp  = swap ? b_exp  : a_exp;
    big_frac = swap ? b_frac : a_frac;
    sml_exp  = swap ? a_exp  : b_exp;
    sml_frac = swap ? a_frac : b_frac;
    shift_d  = big_exp - sml_exp;

    al_ma = {1'b1, big_frac, 3'b000};
    wide  = {1'b1, sml_frac, 3'b000, {XW{1'b0}}} >> shift_d;
    if (32'(shift_d) >= SHIFT_LIM) begin
      // Entire smaller operand lies below the round bit: only sticky survives.
      al_mb = {{(XW-1){1'b0}}, 1'b1};
    end else begin
      al_mb = wide[2*XW-1:XW] | {{(XW-1){1'b0}}, |wide[XW-1:0]};
    end

    al_spec     = 1'b1;
    al_spec_res = '0;
    al_spec_flg = '0;
    if (a_nan || b_nan) begin
      al_spec_res = QNAN;
    end else if (a_inf && b_inf) begin
      if (a_sign != b_sign) begin
        al_spec_res          = QNAN;
        al_spec_flg[FLG_INV] = 1'b1;
      end else begin
        al_spec_res = {a_sign, EXP_ONES, {FRAC_W{1'b0}}};
      end
    end else if (a_inf) begin
      al_spec_res = {a_sign, EXP_ONES, {FRAC_W{1'b0}}};
    end else if (b_inf) begin
      al_spec_res = {b_sign, EXP_ONES, {FRAC_W{1'b0}}};
    end else if (a_zero && b_zero) begin
      // Only (-0)+(-0) keeps the negative sign.
      al_spec_res = {a_sign & b_sign, {(EXP_W + FRAC_W){1'b0}}};
    end else if (a_zero) begin
      al_spec_res = {b_sign, b_exp, b_frac};
    end else if (b_zero) begin
      al_spec_res = {a_sign, a_exp, a_frac};
    end else begin
      al_spec = 1'b0;
    end
  end

  logic                  s1_sign_q, s1_sign_d;
  logic [EXP_W-1:0]      s1_exp_q, s1_exp_d;
  logic [XW-1:0]         s1_ma_q, s1_ma_d;
  logic [XW-1:0]         s1_mb_q, s1_mb_d;
  logic                  s1_sub_q, s1_sub_d;
  logic                  s1_spec_q, s1_spec_d;
  logic [DATA_WIDTH-1:0] s1_spec_res_q, s1_spec_res_d;
  logic [3:0]            s1_spec_flg_q, s1_spec_flg_d;

  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_sign_d     = s1_sign_q;
    s1_exp_d      = s1_exp_q;
    s1_ma_d       = s1_ma_q;
    s1_mb_d       = s1_mb_q;
    s1_sub_d      = s1_sub_q;
    s1_spec_d     = s1_spec_q;
    s1_spec_res_d = s1_spec_res_q;
    s1_spec_flg_d = s1_spec_flg_q;
    if (s1_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sign_d     = big_sign;
        s1_exp_d      = big_exp;
        s1_ma_d       = al_ma;
        s1_mb_d       = al_mb;
        s1_sub_d      = a_sign ^ b_sign;
        s1_spec_d     = al_spec;
        s1_spec_res_d = al_spec_res;
        s1_spec_flg_d = al_spec_flg;
      end
    end
  end

  // ---------------------------------------------------------------- stage 2: add
  logic [XW:0]           add_sum;
  logic                  s2_sign_q, s2_sign_d;
  logic [EXP_W-1:0]      s2_exp_q, s2_exp_d;
  logic [XW:0]           s2_sum_q, s2_sum_d;
  logic                  s2_spec_q, s2_spec_d;
  logic [DATA_WIDTH-1:0] s2_spec_res_q, s2_spec_res_d;
  logic [3:0]            s2_spec_flg_q, s2_spec_flg_d;

  always_comb begin
    // |A| >= |B| after the swap, so the difference never goes negative.
    if (s1_sub_q) add_sum = {1'b0, s1_ma_q - s1_mb_q};
    else          add_sum = {1'b0, s1_ma_q} + {1'b0, s1_mb_q};

    s2_valid_d    = s2_valid_q;
    s2_sign_d     = s2_sign_q;
    s2_exp_d      = s2_exp_q;
    s2_sum_d      = s2_sum_q;
    s2_spec_d     = s2_spec_q;
    s2_spec_res_d = s2_spec_res_q;
    s2_spec_flg_d = s2_spec_flg_q;
    if (s2_ready) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_sign_d     = s1_sign_q;
        s2_exp_d      = s1_exp_q;
        s2_sum_d      = add_sum;
        s2_spec_d     = s1_spec_q;
        s2_spec_res_d = s1_spec_res_q;
        s2_spec_flg_d = s1_spec_flg_q;
      end
    end
  end

  // ---------------------------------------------------------------- stage 3: normalise/round
  logic [DATA_WIDTH-1:0] nr_res;
  logic [3:0]            nr_flg;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic [3:0]            flags_q, flags_d;

  fp_norm_round #(
    .EXP_W  (EXP_W),
    .FRAC_W (FRAC_W)
  ) u_norm_round (
    .sign     (s2_sign_q),
    .exp_in   (s2_exp_q),
    .sum      (s2_sum_q),
    .spec     (s2_spec_q),
    .spec_res (s2_spec_res_q),
    .spec_flg (s2_spec_flg_q),
    .res      (nr_res),
    .flg      (nr_flg)
  );

  always_comb begin
    s3_valid_d = s3_valid_q;
    out_d      = out_q;
    flags_d    = flags_q;
    if (s3_ready) begin
      s3_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        out_d   = nr_res;
        flags_d = nr_flg;
      end
    end
  end

  assign out   = out_q;
  assign flags = flags_q;

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_sign_q     <= 1'b0;
      s1_exp_q      <= '0;
      s1_ma_q       <= '0;
      s1_mb_q       <= '0;
      s1_sub_q      <= 1'b0;
      s1_spec_q     <= 1'b0;
      s1_spec_res_q <= '0;
      s1_spec_flg_q <= '0;
      s2_valid_q    <= 1'b0;
      s2_sign_q     <= 1'b0;
      s2_exp_q      <= '0;
      s2_sum_q      <= '0;
      s2_spec_q     <= 1'b0;
      s2_spec_res_q <= '0;
      s2_spec_flg_q <= '0;
      s3_valid_q    <= 1'b0;
      out_q         <= '0;
      flags_q       <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_sign_q     <= s1_sign_d;
      s1_exp_q      <= s1_exp_d;
      s1_ma_q       <= s1_ma_d;
      s1_mb_q       <= s1_mb_d;
      s1_sub_q      <= s1_sub_d;
      s1_spec_q     <= s1_spec_d;
      s1_spec_res_q <= s1_spec_res_d;
      s1_spec_flg_q <= s1_spec_flg_d;
      s2_valid_q    <= s2_valid_d;
      s2_sign_q     <= s2_sign_d;
      s2_exp_q      <= s2_exp_d;
      s2_sum_q      <= s2_sum_d;
      s2_spec_q     <= s2_spec_d;
      s2_spec_res_q <= s2_spec_res_d;
      s2_spec_flg_q <= s2_spec_flg_d;
      s3_valid_q    <= s3_valid_d;
      out_q         <= out_d;
      flags_q       <= flags_d;
    end
  end

endmodule
`default_nettype wire
